// File: rtl/cpu6_shifter_if.sv
// Execute-stage shift bus between the pipeline control and the multi-cycle shifter.
interface cpu6_shifter_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               shft_en;
    logic               shft_lr;
    logic               shft_arith;
    logic [XLEN-1:0]    shft_a;
    logic [SHAMT_W-1:0] shft_amt;
    logic               flush;
    logic               shft_busy;
    logic               shft_vld;
    logic [XLEN-1:0]    shft_res;

    modport master (
        output shft_en, shft_lr, shft_arith, shft_a, shft_amt, flush,
        input  shft_busy, shft_vld, shft_res
    );

    modport slave (
        input  shft_en, shft_lr, shft_arith, shft_a, shft_amt, flush,
        output shft_busy, shft_vld, shft_res
    );
endinterface

// File: rtl/cpu6_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: shifts up to STEP positions per cycle and stalls
// the pipeline through shft_busy until the result pulse.
module cpu6_shifter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned STEP    = 4,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    cpu6_shifter_if.slave     bus
);
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic               sign_q, sign_d;
    logic               vld_q, vld_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               busy_c;

    logic [SHAMT_W-1:0] step_n;
    logic [2*XLEN-1:0]  right_ext;

    // Per-cycle step size and right-shift with sign/zero fill from the upper half
    always_comb begin
        step_n    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        right_ext = {{XLEN{arith_q & sign_q}}, acc_q} >> step_n;
    end

    // Next-state, datapath and stall logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        sign_d  = sign_q;
        busy_c  = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_c = bus.shft_en;
                    if (bus.shft_en) begin
                        acc_d   = bus.shft_a;
                        rem_d   = bus.shft_amt;
                        dir_d   = bus.shft_lr;
                        arith_d = bus.shft_arith & bus.shft_lr;
                        sign_d  = bus.shft_a[XLEN-1];
                        state_d = (bus.shft_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    busy_c = 1'b1;
                    acc_d  = dir_q ? right_ext[XLEN-1:0] : (acc_q << step_n);
                    rem_d  = rem_q - step_n;
                    if (rem_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // shft_en here is the finishing instruction leaving the stage
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        vld_d = (state_d == DONE);
        res_d = (state_d == DONE) ? acc_d : res_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
            vld_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
            sign_q  <= sign_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
        end
    end

    assign bus.shft_busy = busy_c;
    assign bus.shft_vld  = vld_q;
    assign bus.shft_res  = res_q;
endmodule

// File: doc/cpu6_shifter.md
Name: cpu6_shifter

Overview:
Multi-cycle shift unit that consumes the shift controls produced by the cpu6 ALU decoder (shft_en, shft_lr) plus the SRA/SRAI select taken from instruction bit 30. It sits in the execute stage alongside the single-cycle ALU. It iterates up to STEP bit positions per cycle and stalls the pipeline through shft_busy until the result is ready.

Parameters:
XLEN, 32, operand/result width
STEP, 4, maximum bit positions shifted per cycle; legal values are 1, 2, 4, 8
SHAMT_W, 5, shift-amount width; equals log2(XLEN)

Ports:
clk  input  1  core clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
shft_en  input  1  execute-stage instruction is SLL/SLLI/SRL/SRLI/SRA/SRAI; already qualified with stage valid
shft_lr  input  1  direction: 1 = right, 0 = left
shft_arith  input  1  1 = arithmetic right shift (funct7 = 0100000); ignored when shft_lr = 0
shft_a  input  XLEN  operand (rs1)
shft_amt  input  SHAMT_W  shift amount (rs2[4:0] or imm[4:0])
flush  input  1  synchronous kill of the in-flight shift (branch/trap redirect)
shft_busy  output  1  stall request to the pipeline
shft_vld  output  1  one-cycle pulse: shft_res is valid
shft_res  output  XLEN  shift result

Behaviour:
- Reset (asynchronous, while reset=1): state=IDLE, shft_vld=0, shft_res=0, captured operand/amount/flags=0, shft_busy=0.
- Internal registers: acc[XLEN], rem[SHAMT_W], dir, arith, sign (operand bit XLEN-1 captured at start).
- FSM states:
  - IDLE
    - shft_busy = shft_en (combinational).
    - On a clock edge with shft_en=1 and flush=0: capture acc=shft_a, rem=shft_amt, dir=shft_lr, arith=shft_arith & shft_lr, sign=shft_a[XLEN-1].
    - If shft_amt=0, go to DONE; otherwise go to SHIFT.
  - SHIFT
    - shft_busy=1.
    - Each cycle, n = min(rem, STEP).
    - Left: acc <= acc << n, zero fill.
    - Right logical: zero fill. Right arithmetic: fill with the captured sign.
    - rem <= rem - n. When rem - n = 0, go to DONE.
  - DONE
    - shft_busy=0, shft_vld=1, shft_res=acc.
    - shft_en is ignored in this cycle; it is the same instruction leaving the stage.
    - Next state is IDLE.
- shft_res is registered. It holds its last value until the next DONE and is meaningful only while shft_vld=1.
- Latency, counted from capture edge N (the edge at which IDLE samples shft_en=1):
  - Each shift step takes one clock edge; the DONE cycle (shft_vld=1, shft_busy=0) begins after the final step.
  - Total shift steps = ceil(shft_amt/STEP).
  - shft_amt=0: shft_vld in the cycle following edge N.
  - shft_amt=k>0: shft_vld after edge N + ceil(k/STEP).
  - Worst case with STEP=4, amt=31: 8 SHIFT cycles.
- shft_busy is high from the cycle shft_en is first seen in IDLE through the last SHIFT cycle. It is low in DONE.
- Back-to-back shifts: the next instruction is presented after DONE. IDLE accepts it with no bubble beyond DONE→IDLE.
- Flush:
  - Priority is reset > flush > normal operation.
  - flush=1 at any edge forces state=IDLE and shft_vld=0; shft_res is unchanged.
  - flush in IDLE with shft_en=1 prevents capture.
  - shft_busy is forced to 0 combinationally while flush=1.
- Reset mid-operation aborts immediately with no result pulse. The first shift after reset release behaves as from a clean IDLE.
- Arithmetic is width-exact: bits shifted out are discarded. There is no overflow or status output.

Test Plan:
1. SLL: shft_a=0x0000_0001, amt=31, lr=0, STEP=4, shft_en at edge N -> shft_busy high N..N+7, shft_vld single pulse after edge N+8, shft_res=0x8000_0000.
2. SRA: shft_a=0x8000_0000, amt=5, lr=1, arith=1 -> SHIFT steps of 4 then 1, shft_vld after edge N+2, shft_res=0xFC00_0000.
   - Repeat with arith=0 (SRL) -> shft_res=0x0400_0000.
   - Repeat with lr=0, arith=1 -> shft_res=0x0000_0000 (arith ignored on left).
3. Zero amount: shft_a=0x1234_5678, amt=0 -> shft_vld after edge N, shft_res=0x1234_5678, exactly one busy cycle.
4. Back-to-back: SRL 0xF000_0000 by 8, then SLLI 0x0000_00FF by 4 presented the cycle after DONE -> results 0x00F0_0000 then 0x0000_0FF0, each with a single shft_vld pulse.
5. Flush: start SLL amt=20, assert flush for one cycle in the 2nd SHIFT cycle -> IDLE next edge, no shft_vld, busy low.
   - Then SRA 0xFFFF_FF00 by 8 -> 0xFFFF_FFFF with correct latency.
6. Reset: assert reset asynchronously mid-SHIFT (between edges) -> shft_vld=0, shft_res=0, shft_busy=0 immediately.
   - After release, SRL 0x8000_0000 by 31 -> 0x0000_0001 after 8 SHIFT cycles.
